// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port word memory between instruction fetch (read-only) and data access (read/write).
// Latency: a request sampled in IDLE at edge k is acked in cycle k+2 (k+1 if misaligned); one transaction per 3 cycles.
// Backpressure: requesters hold req and payload until ack; requests are sampled only in IDLE, and ties alternate round-robin.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   i_req, i_addr                      fetch request (byte address, held until i_ack)
//   i_ack, i_rdata, i_err              one-cycle ack pulse, registered fetched word, misalignment flag
//   d_req, d_we, d_addr, d_wdata       data request (held until d_ack)
//   d_ack, d_rdata, d_err              one-cycle ack pulse, registered read word (0 on writes), misalignment flag
//   m_address, m_memIn, m_read,
//   m_write, m_memOut                  memory side; m_memOut is a combinational read of m_address
//   conflicts                          saturating count of IDLE cycles where both ports requested
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ack,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic [WIDTH-1:0] m_address,
  output logic [WIDTH-1:0] m_memIn,
  output logic             m_read,
  output logic             m_write,
  input  logic [WIDTH-1:0] m_memOut,
  output logic [CNT_W-1:0] conflicts
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // owner / last encoding: 0 = fetch port, 1 = data port
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic             owner;
  logic             last;
  logic             lat_we;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] memin_q;

  logic             any_req;
  logic             both_req;
  logic             grant_d;
  logic [WIDTH-1:0] sel_addr;
  logic             sel_we;
  logic             sel_misaligned;
  logic             in_access;

  assign any_req  = i_req | d_req;
  assign both_req = i_req & d_req;

  // On a tie the port that did not go last wins; with last reset to the data
  // port, fetch wins the first tie.
  assign grant_d        = both_req ? ~last : d_req;
  assign sel_addr       = grant_d ? d_addr : i_addr;
  assign sel_we         = grant_d & d_we;
  assign sel_misaligned = (sel_addr[1:0] != 2'b00);

  assign in_access = (state == S_ACCESS);

  // Strobes are gated with reset so a write in flight never commits on the
  // reset edge.
  assign m_read    = in_access & ~lat_we & ~reset;
  assign m_write   = in_access &  lat_we & ~reset;

  // Address and write data are only reloaded when a memory cycle is about to
  // start, so they hold their last values outside ACCESS.
  assign m_address = addr_q;
  assign m_memIn   = memin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      last      <= OWN_D;
      lat_we    <= 1'b0;
      addr_q    <= '0;
      memin_q   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      conflicts <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner  <= grant_d;
            // Priority rotates at grant time so a misaligned request, which
            // never reaches ACCESS, cannot starve the other port.
            last   <= grant_d;
            lat_we <= sel_we;
            if (both_req && (conflicts != CNT_MAX)) begin
              conflicts <= conflicts + CNT_ONE;
            end
            if (sel_misaligned) begin
              // No memory cycle: answer directly with an error.
              state <= S_RESP;
              if (grant_d) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
            end else begin
              state  <= S_ACCESS;
              addr_q <= sel_addr;
              if (sel_we) begin
                memin_q <= d_wdata;
              end
            end
          end
        end
        S_ACCESS: begin
          state <= S_RESP;
          if (owner == OWN_D) begin
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
            d_rdata <= lat_we ? '0 : m_memOut;
          end else begin
            i_ack   <= 1'b1;
            i_err   <= 1'b0;
            i_rdata <= m_memOut;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level reference model predicts each
// ack (port, cycle, data, error, conflict count) into a queue; a monitor pops
// and compares whenever the DUT raises an ack.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic             i_ack;
  logic [WIDTH-1:0] i_rdata;
  logic             i_err;
  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_ack;
  logic [WIDTH-1:0] d_rdata;
  logic             d_err;
  logic [WIDTH-1:0] m_address;
  logic [WIDTH-1:0] m_memIn;
  logic             m_read;
  logic             m_write;
  logic [WIDTH-1:0] m_memOut;
  logic [CW-1:0]    conflicts;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_address(m_address), .m_memIn(m_memIn), .m_read(m_read), .m_write(m_write),
    .m_memOut(m_memOut), .conflicts(conflicts)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(int idx);
    if (idx == 32) return 32'h8C220004;       // byte address 128
    if (idx == 36) return 32'h12345678;       // byte address 144
    return (32'(idx) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Memory instance stand-in: combinational read, write on posedge.
  logic [31:0] dev_mem [0:255];
  bit          mem_ready = 1'b0;
  assign m_memOut = dev_mem[m_address[9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (m_write) begin
      dev_mem[m_address[9:2]] <= m_memIn;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (no ack within cycle budget)", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          port;     // 0 fetch, 1 data
    logic [31:0] rdata;
    bit          err;
    int          ack_cyc;
    int          conf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:255];
  int          cyc = 0;
  int          epoch = 0;

  initial begin
    int          next_free;
    bit          last_d;
    int          conf_m;
    bit          pend_wr;
    int          pend_idx;
    logic [31:0] pend_dat;
    bit          own_d;
    logic [31:0] a;
    exp_t        e;
    next_free = 0; last_d = 1'b1; conf_m = 0; pend_wr = 1'b0; pend_idx = 0; pend_dat = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      cyc++;
      // A write lands at the edge after it was accepted, unless reset hits it.
      if (pend_wr) begin
        if (!reset) ref_mem[pend_idx] = pend_dat;
        pend_wr = 1'b0;
      end
      if (reset) begin
        last_d = 1'b1; conf_m = 0; next_free = cyc + 1; epoch++;
      end else if (cyc >= next_free && (i_req || d_req)) begin
        own_d = (i_req && d_req) ? !last_d : d_req;
        if (i_req && d_req && conf_m < CMAX) conf_m++;
        last_d = own_d;
        a = own_d ? d_addr : i_addr;
        e.port = own_d;
        e.conf = conf_m;
        if (a[1:0] != 2'b00) begin
          e.err = 1'b1; e.rdata = '0; e.ack_cyc = cyc; next_free = cyc + 2;
        end else begin
          e.err = 1'b0; e.ack_cyc = cyc + 1; next_free = cyc + 3;
          if (own_d && d_we) begin
            e.rdata = '0; pend_wr = 1'b1; pend_idx = int'(a[9:2]); pend_dat = d_wdata;
          end else begin
            e.rdata = ref_mem[a[9:2]];
          end
        end
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  int mread_cnt = 0;
  initial begin
    int          seen_epoch;
    logic [31:0] hold_i, hold_d;
    bit          herr_i, herr_d;
    exp_t        e;
    seen_epoch = 0; hold_i = '0; hold_d = '0; herr_i = 1'b0; herr_d = 1'b0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        exp_q.delete();
        hold_i = '0; hold_d = '0; herr_i = 1'b0; herr_d = 1'b0;
      end
      if (m_read) mread_cnt++;
      if (m_read && m_write) begin
        checks++; errors++;
        $display("FAIL mem_rw_overlap m_read=1 m_write=1 at cycle %0d", cyc);
      end
      if (i_ack && d_ack) begin
        checks++; errors++;
        $display("FAIL dual_ack both acks high at cycle %0d", cyc);
      end
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack i_ack=%0b d_ack=%0b at cycle %0d, none expected", i_ack, d_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'(d_ack), 32'(e.port));
          check("ack_cycle", cyc, e.ack_cyc);
          check("conflicts_at_ack", 32'(conflicts), e.conf);
          if (e.port) begin hold_d = e.rdata; herr_d = e.err; end
          else        begin hold_i = e.rdata; herr_i = e.err; end
        end
      end
      check("i_rdata", i_rdata, hold_i);
      check("i_err", 32'(i_err), 32'(herr_i));
      check("d_rdata", d_rdata, hold_d);
      check("d_err", 32'(d_err), 32'(herr_d));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input bit port, input string name, output int n);
    bit got;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = port ? d_ack : i_ack;
    end
    if (!got) fail_now(name);
  endtask

  task automatic wait_any(input string name, output bit port, output int n);
    bit got;
    got = 1'b0; n = 0; port = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = i_ack || d_ack;
    end
    if (!got) fail_now(name);
    else port = d_ack;
  endtask

  task automatic drive_fetch(input int count);
    int n;
    int gap;
    for (int t = 0; t < count; t++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        i_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      i_addr = 32'($urandom_range(0, 255)) << 2;
      i_req  = 1'b1;
      wait_ack(1'b0, "rand_fetch_ack", n);
    end
    i_req = 1'b0;
  endtask

  task automatic drive_data(input int count);
    int n;
    int gap;
    for (int t = 0; t < count; t++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        d_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
      d_addr  = 32'($urandom_range(0, 255)) << 2;
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      d_req   = 1'b1;
      wait_ack(1'b1, "rand_data_ack", n);
    end
    d_req = 1'b0;
  endtask

  initial begin
    int n;
    int snap;
    int mism;
    bit p;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_i_ack", 32'(i_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_i_err", 32'(i_err), 0);
    check("rst_d_err", 32'(d_err), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_conflicts", 32'(conflicts), 0);
    check("rst_m_read", 32'(m_read), 0);
    check("rst_m_write", 32'(m_write), 0);

    // 1: single fetch, ack in cycle 3
    reset = 1'b0;
    i_addr = 32'd128; i_req = 1'b1;
    wait_ack(1'b0, "t1_ack", n);
    check("t1_latency_cycle", n + 1, 3);
    check("t1_i_rdata", i_rdata, 32'h8C220004);
    check("t1_i_err", 32'(i_err), 0);
    i_req = 1'b0;

    // dropping req after the latch still completes
    repeat (2) @(negedge clk);
    i_addr = 32'd136; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    wait_ack(1'b0, "t1b_dropped_req_ack", n);
    check("t1b_latency", n, 1);

    // 2: both held from reset release -> I,D,I,D, 3 cycles apart
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    i_addr = 32'd132; d_addr = 32'd200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any("t2_ack", p, n);
      check("t2_order", 32'(p), 32'(k % 2));
      check("t2_spacing", n, (k == 0) ? 2 : 3);
    end
    i_req = 1'b0; d_req = 1'b0;
    check("t2_conflicts", 32'(conflicts), 4);

    // 3: write then fetch the same word
    repeat (2) @(negedge clk);
    d_we = 1'b1; d_addr = 32'd140; d_wdata = 32'h00000020; d_req = 1'b1;
    wait_ack(1'b1, "t3_write_ack", n);
    check("t3_d_rdata", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd140; i_req = 1'b1;
    wait_ack(1'b0, "t3_fetch_ack", n);
    check("t3_i_rdata", i_rdata, 32'h00000020);
    i_req = 1'b0;

    // 4: misaligned fetch, no memory cycle
    repeat (2) @(negedge clk);
    snap = mread_cnt;
    i_addr = 32'd130; i_req = 1'b1;
    wait_ack(1'b0, "t4_ack", n);
    check("t4_latency_cycle", n + 1, 2);
    check("t4_i_err", 32'(i_err), 1);
    check("t4_i_rdata", i_rdata, 0);
    check("t4_no_m_read", mread_cnt, snap);
    i_req = 1'b0;

    // 5: reset lands during a write's ACCESS cycle
    repeat (3) @(negedge clk);
    d_we = 1'b1; d_addr = 32'd144; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    @(negedge clk);
    check("t5_m_write_in_access", 32'(m_write), 1);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    #1;
    check("t5_m_write_gated", 32'(m_write), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t5_mem144", dev_mem[36], 32'h12345678);
    check("t5_conflicts", 32'(conflicts), 0);
    i_addr = 32'd128; d_addr = 32'd200; i_req = 1'b1; d_req = 1'b1;
    wait_any("t5_first_tie", p, n);
    check("t5_fetch_wins", 32'(p), 0);
    i_req = 1'b0;
    wait_ack(1'b1, "t5_data_ack", n);
    d_req = 1'b0;

    // 6: sustained contention saturates the counter
    repeat (2) @(negedge clk);
    i_addr = 32'd40; d_addr = 32'd80; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 20; k++) wait_any("t6_ack", p, n);
    i_req = 1'b0; d_req = 1'b0;
    check("t6_conflicts_saturated", 32'(conflicts), CMAX);

    // randomized traffic on both ports
    repeat (2) @(negedge clk);
    fork
      drive_fetch(40);
      drive_data(40);
    join
    repeat (6) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
    check("final_mem_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
